mavg_sched: RTL and testbench

Shared moving-average filter engine with a built-in scheduler for the QAM baseband path. Two sample streams, I and Q, compete for one running-sum datapath and one history store. A round-robin arbiter grants one of them per cycle, and each result is tagged with its channel. Window length is runtime-configurable as a power of two, and any reconfiguration runs a history-clear sequence before filtering resumes.

---
 rtl/qam_pkg.sv | 14 +
 rtl/mavg_hist_rf.sv | 27 ++
 rtl/mavg_sched.sv | 156 +++++++++++++++
 tb/tb_mavg_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared constants and types for the QAM baseband moving-average path.
package qam_pkg;
  localparam int SAMPLE_W  = 16;
  localparam int MAX_LOG2N = 4;
  localparam int HIST_D    = 1 << MAX_LOG2N;
  localparam int SUM_W     = SAMPLE_W + MAX_LOG2N;

  typedef enum logic {CH_I = 1'b0, CH_Q = 1'b1} chan_e;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  function automatic logic [2:0] clamp_log2n(input logic [2:0] v);
    return (v > 3'(MAX_LOG2N)) ? 3'(MAX_LOG2N) : v;
  endfunction
endpackage

// File: rtl/mavg_hist_rf.sv
// Per-channel sample history: one async read and one sync write port per channel, no reset.
module mavg_hist_rf
  import qam_pkg::*;
(
  input  logic                 clk,
  input  logic [MAX_LOG2N-1:0] rd_addr_i,
  output logic [SAMPLE_W-1:0]  rd_data_i,
  input  logic [MAX_LOG2N-1:0] rd_addr_q,
  output logic [SAMPLE_W-1:0]  rd_data_q,
  input  logic                 we_i,
  input  logic [MAX_LOG2N-1:0] wr_addr_i,
  input  logic [SAMPLE_W-1:0]  wr_data_i,
  input  logic                 we_q,
  input  logic [MAX_LOG2N-1:0] wr_addr_q,
  input  logic [SAMPLE_W-1:0]  wr_data_q
);
  logic [SAMPLE_W-1:0] mem_i_q [HIST_D];
  logic [SAMPLE_W-1:0] mem_q_q [HIST_D];

  always_ff @(posedge clk) begin
    if (we_i) mem_i_q[wr_addr_i] <= wr_data_i;
    if (we_q) mem_q_q[wr_addr_q] <= wr_data_q;
  end

  assign rd_data_i = mem_i_q[rd_addr_i];
  assign rd_data_q = mem_q_q[rd_addr_q];
endmodule

// File: rtl/mavg_sched.sv
// Two-channel (I/Q) moving-average engine sharing one running-sum datapath,
// with round-robin arbitration and a history-clear sequence on reconfiguration.
module mavg_sched
  import qam_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          cfg_log2n,
  input  logic                cfg_load,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [SAMPLE_W-1:0] i_data,
  input  logic                q_valid,
  output logic                q_ready,
  input  logic [SAMPLE_W-1:0] q_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_chan,
  output logic                busy
);
  state_e                     state_q, state_d;
  chan_e                      last_q, last_d;
  logic [MAX_LOG2N-1:0]       clr_idx_q, clr_idx_d;
  logic [2:0]                 log2n_q, log2n_d;
  logic signed [SUM_W-1:0]    sum_i_q, sum_i_d, sum_q_q, sum_q_d;
  logic [MAX_LOG2N-1:0]       wp_i_q, wp_i_d, wp_q_q, wp_q_d;
  logic                       out_valid_q, out_valid_d;
  logic [SAMPLE_W-1:0]        out_data_q, out_data_d;
  logic                       out_chan_q, out_chan_d;

  logic                       grant_i, grant_q, accept;
  logic [SAMPLE_W-1:0]        rd_i, rd_q;
  logic signed [SAMPLE_W-1:0] x, old;
  logic signed [SUM_W-1:0]    sum_sel, sum_new;
  logic [MAX_LOG2N-1:0]       wp_sel, wp_next, n_m1;
  logic [MAX_LOG2N:0]         n_full;

  // Arithmetic shift floors toward minus infinity; the average always fits a sample.
  function automatic logic [SAMPLE_W-1:0] avg_shift(input logic signed [SUM_W-1:0] s,
                                                    input logic [2:0] sh);
    logic signed [SUM_W-1:0] t;
    t = s >>> sh;
    return t[SAMPLE_W-1:0];
  endfunction

  // A cfg_load cycle never accepts, so a pulse cannot race with a transfer.
  always_comb begin
    grant_i = 1'b0;
    grant_q = 1'b0;
    if (state_q == RUN && !cfg_load && (!out_valid_q || out_ready)) begin
      if (i_valid && (!q_valid || last_q == CH_Q)) grant_i = 1'b1;
      else if (q_valid)                            grant_q = 1'b1;
    end
  end

  assign accept  = grant_i | grant_q;
  assign x       = grant_q ? q_data : i_data;
  assign old     = grant_q ? rd_q : rd_i;
  assign sum_sel = grant_q ? sum_q_q : sum_i_q;
  assign wp_sel  = grant_q ? wp_q_q : wp_i_q;
  assign sum_new = sum_sel + SUM_W'(x) - SUM_W'(old);
  assign n_full  = (MAX_LOG2N+1)'(1) << log2n_q;
  assign n_m1    = MAX_LOG2N'(n_full - 1'b1);
  assign wp_next = (wp_sel == n_m1) ? '0 : wp_sel + 1'b1;

  mavg_hist_rf u_hist (
    .clk       (clk),
    .rd_addr_i (wp_i_q),
    .rd_data_i (rd_i),
    .rd_addr_q (wp_q_q),
    .rd_data_q (rd_q),
    .we_i      (state_q == CLEAR || grant_i),
    .wr_addr_i (state_q == CLEAR ? clr_idx_q : wp_i_q),
    .wr_data_i (state_q == CLEAR ? '0 : i_data),
    .we_q      (state_q == CLEAR || grant_q),
    .wr_addr_q (state_q == CLEAR ? clr_idx_q : wp_q_q),
    .wr_data_q (state_q == CLEAR ? '0 : q_data)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    clr_idx_d   = clr_idx_q;
    log2n_d     = log2n_q;
    sum_i_d     = sum_i_q;
    sum_q_d     = sum_q_q;
    wp_i_d      = wp_i_q;
    wp_q_d      = wp_q_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (cfg_load) begin
      state_d     = CLEAR;
      clr_idx_d   = '0;
      log2n_d     = clamp_log2n(cfg_log2n);
      out_valid_d = 1'b0;
    end else if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      sum_i_d   = '0;
      sum_q_d   = '0;
      wp_i_d    = '0;
      wp_q_d    = '0;
      if (clr_idx_q == MAX_LOG2N'(HIST_D - 1)) state_d = RUN;
    end else if (accept) begin
      last_d      = grant_q ? CH_Q : CH_I;
      out_valid_d = 1'b1;
      out_data_d  = avg_shift(sum_new, log2n_q);
      out_chan_d  = grant_q;
      if (grant_q) begin
        sum_q_d = sum_new;
        wp_q_d  = wp_next;
      end else begin
        sum_i_d = sum_new;
        wp_i_d  = wp_next;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      last_q      <= CH_Q;
      clr_idx_q   <= '0;
      log2n_q     <= 3'(MAX_LOG2N);
      sum_i_q     <= '0;
      sum_q_q     <= '0;
      wp_i_q      <= '0;
      wp_q_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      clr_idx_q   <= clr_idx_d;
      log2n_q     <= log2n_d;
      sum_i_q     <= sum_i_d;
      sum_q_q     <= sum_q_d;
      wp_i_q      <= wp_i_d;
      wp_q_q      <= wp_q_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign i_ready   = grant_i;
  assign q_ready   = grant_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign busy      = (state_q == CLEAR);
endmodule

// File: tb/tb_mavg_sched.sv
// Randomized bench for mavg_sched against a window-sum reference model of both channels.
module tb_mavg_sched;
  logic        clk, rst, cfg_load, i_valid, i_ready, q_valid, q_ready;
  logic        out_valid, out_ready, out_chan, busy;
  logic [2:0]  cfg_log2n;
  logic [15:0] i_data, q_data, out_data;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          hi[$];
  int          hq[$];
  int          m_n, m_last, m_busy_left;
  logic        exp_valid, exp_chan, e_ir, e_qr, e_busy, o_ir, o_qr;
  logic [15:0] exp_data;

  mavg_sched dut (
    .clk(clk), .rst(rst), .cfg_log2n(cfg_log2n), .cfg_load(cfg_load),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Floor of the mean of the last N accepted samples, with zeros before the first.
  function automatic int avg_of(input logic ch);
    int s, nn, cnt, q;
    s   = 0;
    nn  = 1 << m_n;
    cnt = ch ? hq.size() : hi.size();
    for (int k = 0; k < nn && k < cnt; k++) s += ch ? hq[cnt-1-k] : hi[cnt-1-k];
    q = s / nn;
    if (s < 0 && q * nn != s) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    hi.delete();
    hq.delete();
    m_n = 4; m_last = 1; m_busy_left = 16;
    exp_valid = 1'b0; exp_chan = 1'b0; exp_data = '0; e_busy = 1'b1;
  endtask

  // One clock cycle: drive at negedge, sample readies, advance model, return at next negedge.
  task automatic tick(input logic cfg, input int cfgn, input logic iv, input int id,
                      input logic qv, input int qd, input logic ordy);
    cfg_load = cfg; cfg_log2n = 3'(cfgn);
    i_valid = iv; i_data = 16'(id);
    q_valid = qv; q_data = 16'(qd);
    out_ready = ordy;
    #1;
    o_ir = i_ready; o_qr = q_ready;
    e_ir = 1'b0; e_qr = 1'b0;
    if (!cfg && m_busy_left == 0 && (!exp_valid || ordy)) begin
      if (iv && (!qv || m_last == 1)) e_ir = 1'b1;
      else if (qv)                    e_qr = 1'b1;
    end
    @(posedge clk);
    if (cfg) begin
      hi.delete(); hq.delete();
      m_n = (cfgn > 4) ? 4 : cfgn;
      m_busy_left = 16;
      exp_valid = 1'b0;
    end else begin
      if (m_busy_left > 0) m_busy_left--;
      if (e_ir || e_qr) begin
        if (e_qr) hq.push_back(qd); else hi.push_back(id);
        exp_data  = 16'(avg_of(e_qr));
        exp_chan  = e_qr;
        m_last    = e_qr ? 1 : 0;
        exp_valid = 1'b1;
      end else if (ordy) begin
        exp_valid = 1'b0;
      end
    end
    e_busy = (m_busy_left > 0);
    @(negedge clk);
  endtask

  task automatic idle_cfg(input int n);
    tick(1'b1, n, 1'b0, 0, 1'b0, 0, 1'b1);
    repeat (16) tick(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_reset();
    rst = 1'b1; cfg_load = 1'b0; cfg_log2n = '0; i_valid = 1'b1; i_data = '0;
    q_valid = 1'b0; q_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, i_ready, q_ready, out_valid, out_chan, out_data} !== {1'b1, 3'b000, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_vals got busy=%b ir=%b qr=%b ov=%b ch=%b d=%h", busy, i_ready, q_ready,
               out_valid, out_chan, out_data);
    end
    rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 17; k++) begin
      tick(1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b1);
      checks++;
      if (o_ir !== (k == 17)) begin
        errors++;
        $display("FAIL reset_ready cycle %0d got %b exp %b", k, o_ir, k == 17);
      end
      checks++;
      if ({o_ir, o_qr, busy, out_valid, out_chan, out_data} !== {e_ir, e_qr, e_busy, exp_valid, exp_chan, exp_data}) begin
        errors++;
        $display("FAIL reset_seq cycle %0d got %b%b%b%b%b %0d exp %b%b%b%b%b %0d", k, o_ir, o_qr, busy,
                 out_valid, out_chan, $signed(out_data), e_ir, e_qr, e_busy, exp_valid, exp_chan, $signed(exp_data));
      end
    end
  endtask

  task automatic test_const_i();
    int k;
    int lit;
    k = 0;
    idle_cfg(4);
    repeat (20) begin
      tick(1'b0, 0, 1'b1, 100, 1'b0, 0, 1'b1);
      if (e_ir) k++;
      lit = (k < 16) ? (k * 100) / 16 : 100;
      checks++;
      if ($signed(out_data) !== 16'(lit) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL const_i sample %0d got %0d v=%b exp %0d", k, $signed(out_data), out_valid, lit);
      end
    end
  endtask

  task automatic test_alternate();
    int ci, cq, prev;
    ci = 0; cq = 0; prev = -1;
    idle_cfg(2);
    repeat (8) begin
      tick(1'b0, 0, 1'b1, 1000, 1'b1, -1000, 1'b1);
      if (e_qr) cq++; else ci++;
      checks++;
      if ({o_ir, o_qr, out_valid, out_chan, out_data} !== {e_ir, e_qr, exp_valid, exp_chan, exp_data}) begin
        errors++;
        $display("FAIL alt_model got %b%b%b%b %0d exp %b%b%b%b %0d", o_ir, o_qr, out_valid, out_chan,
                 $signed(out_data), e_ir, e_qr, exp_valid, exp_chan, $signed(exp_data));
      end
      checks++;
      if (int'(out_chan) == prev ||
          $signed(out_data) !== (out_chan ? 16'(-250 * ((cq < 4) ? cq : 4)) : 16'(250 * ((ci < 4) ? ci : 4)))) begin
        errors++;
        $display("FAIL alt_values got ch=%b d=%0d prev_ch=%0d ci=%0d cq=%0d", out_chan, $signed(out_data),
                 prev, ci, cq);
      end
      prev = int'(out_chan);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] hold_d;
    logic        hold_c;
    tick(1'b0, 0, 1'b1, rnd_sample(), 1'b1, rnd_sample(), 1'b1);
    hold_d = out_data; hold_c = out_chan;
    repeat (5) begin
      tick(1'b0, 0, 1'b1, rnd_sample(), 1'b1, rnd_sample(), 1'b0);
      checks++;
      if ({o_ir, o_qr, out_valid, out_chan, out_data} !== {3'b001, hold_c, hold_d}) begin
        errors++;
        $display("FAIL bp_hold got ir=%b qr=%b v=%b ch=%b d=%h exp 0 0 1 %b %h", o_ir, o_qr, out_valid,
                 out_chan, out_data, hold_c, hold_d);
      end
    end
    repeat (30) begin
      tick(1'b0, 0, $urandom_range(0, 1), rnd_sample(), $urandom_range(0, 1), rnd_sample(),
           $urandom_range(0, 3) != 0);
      checks++;
      if ({o_ir, o_qr, busy, out_valid, out_chan, out_data} !== {e_ir, e_qr, e_busy, exp_valid, exp_chan, exp_data}) begin
        errors++;
        $display("FAIL bp_resume got %b%b%b%b%b %h exp %b%b%b%b%b %h", o_ir, o_qr, busy, out_valid,
                 out_chan, out_data, e_ir, e_qr, e_busy, exp_valid, exp_chan, exp_data);
      end
    end
  endtask

  task automatic test_extremes();
    idle_cfg(4);
    repeat (16) tick(1'b0, 0, 1'b1, -32768, 1'b0, 0, 1'b1);
    checks++;
    if (out_data !== 16'h8000 || exp_data !== 16'h8000) begin
      errors++;
      $display("FAIL extreme_neg got %0d exp -32768", $signed(out_data));
    end
    repeat (16) tick(1'b0, 0, 1'b1, 32767, 1'b0, 0, 1'b1);
    checks++;
    if (out_data !== 16'h7fff) begin
      errors++;
      $display("FAIL extreme_pos got %0d exp 32767", $signed(out_data));
    end
  endtask

  task automatic test_cfg_midstream();
    repeat (4) tick(1'b0, 0, 1'b1, rnd_sample(), 1'b1, rnd_sample(), 1'b1);
    tick(1'b1, 1, 1'b1, 7, 1'b1, 7, 1'b0);
    checks++;
    if ({o_ir, o_qr, out_valid, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL cfg_flush got ir=%b qr=%b v=%b busy=%b exp 0 0 0 1", o_ir, o_qr, out_valid, busy);
    end
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, 0, 1'b1, 3, 1'b1, 3, 1'b1);
      checks++;
      if ({o_ir, o_qr, out_valid, busy} !== {3'b000, k < 16}) begin
        errors++;
        $display("FAIL cfg_clear cycle %0d got ir=%b qr=%b v=%b busy=%b", k, o_ir, o_qr, out_valid, busy);
      end
    end
    tick(1'b0, 0, 1'b1, 10, 1'b0, 0, 1'b1);
    checks++;
    if (out_data !== 16'd5 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL cfg_first got %0d v=%b exp 5", $signed(out_data), out_valid);
    end
    tick(1'b0, 0, 1'b1, 20, 1'b0, 0, 1'b1);
    checks++;
    if (out_data !== 16'd15 || out_chan !== 1'b0) begin
      errors++;
      $display("FAIL cfg_second got %0d ch=%b exp 15", $signed(out_data), out_chan);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 99) == 0), int'($urandom_range(0, 7)), $urandom_range(0, 1), rnd_sample(),
           $urandom_range(0, 1), rnd_sample(), $urandom_range(0, 3) != 0);
      checks++;
      if ({o_ir, o_qr, busy, out_valid, out_chan, out_data} !== {e_ir, e_qr, e_busy, exp_valid, exp_chan, exp_data}) begin
        errors++;
        $display("FAIL random cycle %0d got %b%b%b%b%b %h exp %b%b%b%b%b %h n=%0d", k, o_ir, o_qr, busy,
                 out_valid, out_chan, out_data, e_ir, e_qr, e_busy, exp_valid, exp_chan, exp_data, m_n);
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (5) tick(1'b0, 0, 1'b1, rnd_sample(), 1'b1, rnd_sample(), 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, i_ready, q_ready, out_valid, out_chan, out_data} !== {1'b1, 3'b000, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_mid got busy=%b ir=%b qr=%b v=%b ch=%b d=%h", busy, i_ready, q_ready,
               out_valid, out_chan, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (40) begin
      tick(1'b0, 0, $urandom_range(0, 1), rnd_sample(), $urandom_range(0, 1), rnd_sample(), 1'b1);
      checks++;
      if ({o_ir, o_qr, busy, out_valid, out_chan, out_data} !== {e_ir, e_qr, e_busy, exp_valid, exp_chan, exp_data}) begin
        errors++;
        $display("FAIL post_reset got %b%b%b%b%b %h exp %b%b%b%b%b %h", o_ir, o_qr, busy, out_valid,
                 out_chan, out_data, e_ir, e_qr, e_busy, exp_valid, exp_chan, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_const_i();
    test_alternate();
    test_backpressure();
    test_extremes();
    test_cfg_midstream();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
